// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and sequencer state encoding for the memory stream reader
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// rtl/mem_stream_reader_if.sv - RAM read port plus valid/ready byte stream bundle
interface mem_stream_reader_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              o_r_en;
  logic [ADDR_W-1:0] o_r_addr;
  logic [DATA_W-1:0] i_r_data;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;

  modport master (
    output o_r_en, o_r_addr, o_data, o_valid, o_last,
    input  i_r_data, i_ready
  );

  modport slave (
    input  o_r_en, o_r_addr, o_data, o_valid, o_last,
    output i_r_data, i_ready
  );

endinterface

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry FIFO that registers returning RAM bytes with their last flag
module stream_fifo2 #(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  // Storage, pointers and fill count; simultaneous push and pop leave count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - sweeps RAM addresses 0..LAST_ADDR and streams each byte out
module mem_stream_reader
  import mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LAST_ADDR = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  mem_stream_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LAST_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              inflight;
  logic              inflight_last;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occ;
  logic [DATA_W:0]   head;

  assign occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pop  = !fifo_empty && bus.i_ready;
  assign push = inflight && !fifo_full;

  // A read is issued only if the buffer can still hold its byte once it lands:
  // occupancy + in-flight - pop <= 1, rearranged to avoid unsigned underflow.
  assign issue = (state == RUN) &&
                 (({1'b0, occ} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop}));

  // Sweep sequencer: issue pointer, read-latency tracking flags and the done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      ptr           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (ptr == LAST_PTR);
      case (state)
        IDLE: begin
          if (i_start && !o_done) begin
            state <= RUN;
            ptr   <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (ptr == LAST_PTR) state <= DRAIN;
            else                 ptr   <= ptr + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && head[DATA_W]) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .din   ({inflight_last, bus.i_r_data}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_busy       = (state != IDLE);
  assign bus.o_r_en   = issue;
  assign bus.o_r_addr = ptr;
  assign bus.o_valid  = !fifo_empty;
  assign bus.o_data   = head[DATA_W-1:0];
  assign bus.o_last   = head[DATA_W] && !fifo_empty;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - scoreboard bench for mem_stream_reader (full sweep and single-byte builds)
module tb_mem_stream_reader;

  logic clk = 1'b0;
  logic rst;
  logic start, start0;
  logic busy, done, busy0, done0;

  int tests = 0;
  int fails = 0;
  int issued = 0;
  int done_cnt = 0;
  logic [8:0] q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] ram [256];

  mem_stream_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_stream_reader_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();

  mem_stream_reader #(.ADDR_W(8), .DATA_W(8), .LAST_ADDR(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done), .bus(bus.master)
  );

  mem_stream_reader #(.ADDR_W(8), .DATA_W(8), .LAST_ADDR(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0),
    .o_busy(busy0), .o_done(done0), .bus(bus0.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_r_en)  bus.i_r_data  <= ram[bus.o_r_addr];
    if (bus0.o_r_en) bus0.i_r_data <= ram[bus0.o_r_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_sweep();
    for (int a = 0; a < 16; a++) q.push_back({(a == 15), 8'(a + 8'h10)});
  endtask

  // Samples the current cycle at the falling edge, then moves to just after the next rising edge.
  task automatic tick();
    logic [8:0] exp;
    @(negedge clk);
    if (!rst) begin
      if (prev_hold) check("hold_data", bus.o_data, prev_data);
      if (bus.o_r_en) issued++;
      if (bus.o_valid && bus.i_ready) begin
        check("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          check("beat_data", bus.o_data, exp[7:0]);
          check("beat_last", bus.o_last, exp[8]);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", q.size(), 0);
      end
      prev_hold = bus.o_valid && !bus.i_ready;
      prev_data = bus.o_data;
    end else begin
      prev_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      if (rnd) bus.i_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("done_within_budget", done, 1);
  endtask

  initial begin
    int base_issued;
    int base_done;
    for (int a = 0; a < 256; a++) ram[a] = 8'(a + 8'h10);
    rst = 1'b1; start = 1'b0; start0 = 1'b0;
    bus.i_ready = 1'b0; bus0.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_r_en", bus.o_r_en, 0);
    check("rst_r_addr", bus.o_r_addr, 0);
    check("rst_data", bus.o_data, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_last", bus.o_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();

    // Full sweep with ready held high.
    bus.i_ready = 1'b1;
    base_done = done_cnt;
    start = 1'b1; load_sweep();
    tick();
    start = 1'b0;
    check("c1_busy", busy, 1);
    check("c1_r_en", bus.o_r_en, 1);
    check("c1_r_addr", bus.o_r_addr, 0);
    tick();
    check("c2_valid", bus.o_valid, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("stream_valid", bus.o_valid, 1);
    end
    tick();
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("done_count_1", done_cnt - base_done, 1);

    // Backpressure: ready low for 10 cycles after start.
    bus.i_ready = 1'b0;
    base_issued = issued;
    base_done = done_cnt;
    start = 1'b1; load_sweep();
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("bp_valid", bus.o_valid, 1);
    check("bp_data", bus.o_data, 8'h10);
    check("bp_reads", issued - base_issued, 2);
    check("bp_r_en", bus.o_r_en, 0);
    bus.i_ready = 1'b1;
    wait_done(100, 1'b0);
    tick();
    check("bp_done_count", done_cnt - base_done, 1);
    check("bp_queue_empty", q.size(), 0);

    // Random ready over a full sweep.
    base_done = done_cnt;
    start = 1'b1; load_sweep();
    tick();
    start = 1'b0;
    wait_done(400, 1'b1);
    bus.i_ready = 1'b1;
    tick();
    check("rnd_done_count", done_cnt - base_done, 1);
    check("rnd_queue_empty", q.size(), 0);

    // Start pulses during RUN and coincident with done are ignored.
    base_done = done_cnt;
    start = 1'b1; load_sweep();
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", busy, 0);
    check("ign_r_en", bus.o_r_en, 0);
    repeat (4) tick();
    check("ign_valid", bus.o_valid, 0);
    check("ign_done_count", done_cnt - base_done, 1);

    // Reset in cycle 6 of a sweep, then a clean restart.
    base_done = done_cnt;
    start = 1'b1; load_sweep();
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_r_en", bus.o_r_en, 0);
    check("mid_rst_r_addr", bus.o_r_addr, 0);
    check("mid_rst_data", bus.o_data, 0);
    check("mid_rst_valid", bus.o_valid, 0);
    check("mid_rst_last", bus.o_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    q.delete();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("mid_rst_no_done", done_cnt - base_done, 0);
    start = 1'b1; load_sweep();
    tick();
    start = 1'b0;
    check("restart_r_en", bus.o_r_en, 1);
    check("restart_r_addr", bus.o_r_addr, 0);
    wait_done(100, 1'b0);
    tick();
    check("restart_done_count", done_cnt - base_done, 1);

    // Single-address build.
    bus0.i_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("one_r_en", bus0.o_r_en, 1);
    check("one_r_addr", bus0.o_r_addr, 0);
    tick();
    check("one_no_second_read", bus0.o_r_en, 0);
    tick();
    check("one_valid", bus0.o_valid, 1);
    check("one_data", bus0.o_data, 8'h10);
    check("one_last", bus0.o_last, 1);
    tick();
    check("one_done", done0, 1);
    check("one_drained", bus0.o_valid, 0);
    tick();
    check("one_done_pulse", done0, 0);
    check("one_idle", busy0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read sequencer that sits directly downstream of the inferred 256x8 block RAM. On a start pulse it sweeps addresses 0..LAST_ADDR, drives the RAM read port, absorbs the RAM's one-cycle read latency, and presents each byte on a valid/ready stream for the next stage (UART TX, LED driver). Backpressure never drops or duplicates a byte.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- LAST_ADDR, 15, final address of the sweep; legal range 0..2^ADDR_W-1
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_start  in  1  start-sweep pulse; sampled only in IDLE
- o_r_en  out  1  RAM read enable
- o_r_addr  out  ADDR_W  RAM read address
- i_r_data  in  DATA_W  RAM read data; valid the cycle after o_r_en=1
- o_data  out  DATA_W  stream byte
- o_valid  out  1  o_data is valid
- i_ready  in  1  downstream accepts; a beat transfers when o_valid && i_ready
- o_last  out  1  qualifies the beat carrying LAST_ADDR's byte
- o_busy  out  1  high from the start edge until the done pulse
- o_done  out  1  one-cycle pulse after the last beat transfers

## Operation
- States:
  - IDLE: i_start=1 -> RUN; issue pointer <- 0.
  - RUN: issue reads. After the read of LAST_ADDR is issued -> DRAIN.
  - DRAIN: no reads. When the last beat transfers -> IDLE, pulse o_done.
- Read issue: o_r_en=1 only when occupancy + in-flight read - (pop this cycle) <= 1.
  - Occupancy is the output buffer fill, 0..2.
  - The in-flight read is the one issued last cycle whose data lands this cycle.
  - This credit rule makes buffer overflow impossible.
- o_r_addr holds the issue pointer; it increments only on an issued read. o_r_addr is don't-care when o_r_en=0 but must hold its value.
- Returning data: a 1-bit in-flight flag delayed from o_r_en writes i_r_data into the buffer. A companion flag marks LAST_ADDR and becomes o_last.
- Output buffer: 2-entry FIFO.
  - Push and pop in the same cycle is legal at any occupancy except push-while-full, which is unreachable.
  - o_valid = buffer not empty; o_data and o_last come from the head entry.
- i_start is ignored in RUN and DRAIN. A start in the same cycle as o_done is also ignored.
- LAST_ADDR=0: one read, one beat, with o_last=1.
- Pointer arithmetic is ADDR_W bits. The sweep ends at LAST_ADDR, so the pointer never wraps.
- i_rst asserted mid-sweep: all state returns to reset values immediately. Buffered bytes are discarded, and no o_done is produced.

## Timing
- Reset values: o_r_en=0, o_r_addr=0, o_data=0, o_valid=0, o_last=0, o_busy=0, o_done=0. State is IDLE and the buffer is empty.
- Start edge at cycle 0:
  - o_busy=1 and o_r_en=1 with addr 0 from cycle 1.
  - Byte 0 is o_valid from cycle 3 (RAM latency 1 + buffer register 1).
- With i_ready held high: one beat per cycle, LAST_ADDR+1 consecutive beats, o_done in the cycle after the last transfer.
- o_busy falls in the same cycle o_done is high.
- With i_ready low: at most 2 reads are outstanding or buffered, and o_r_en stays low until a pop frees a credit.
- o_data and o_last are stable while o_valid && !i_ready.

## Structure
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The state enum (IDLE, RUN, DRAIN).
- Sub-module stream_fifo2: a 2-entry FIFO of width DATA_W+1 (data plus last flag), with push, pop, full, empty and the same clock/reset.
- Top level: FSM, issue pointer, credit logic and in-flight flags. The RAM stays external.

## Test plan
- Reset, then i_start with i_ready=1 and RAM preloaded with mem[a]=a+0x10 -> 16 beats 0x10..0x1F on consecutive cycles starting at cycle 3; o_last only on 0x1F; one o_done pulse.
- i_ready=0 for 10 cycles after start -> o_valid=1 holding 0x10; exactly 2 reads issued; no o_r_en until the first pop; full sequence intact after release.
- Random i_ready (50%) over a full sweep -> received bytes equal 0x10..0x1F in order with no gaps or duplicates; o_done only after the 0x1F beat transfers.
- i_start pulsed during RUN and coincident with o_done -> ignored; a single sweep only.
- i_rst asserted at cycle 6 of a sweep -> all outputs 0 in that cycle; no o_done; a subsequent start restarts at addr 0.
- LAST_ADDR=0 build -> one beat 0x10 with o_last=1, then o_done.
